// File: rtl/tuning_controller.sv
// UART command decoder driving NCO phase increment and CIC gain; single-key updates land 1 cycle after the byte, direct kHz entry lands CR+18.
// No backpressure: bytes arriving while the multiplier runs are dropped and flagged with cmd_error.
module tuning_controller #(
   parameter int                     PHASE_WIDTH = 64,
   parameter int                     GAIN_WIDTH  = 8,
   parameter logic [PHASE_WIDTH-1:0] STEP_100HZ  = 64'h00001436A8CDF6F3,
   parameter logic [PHASE_WIDTH-1:0] STEP_1KHZ   = 64'h0000CA22980BA57E,
   parameter logic [PHASE_WIDTH-1:0] STEP_9KHZ   = 64'h00071B375868D170,
   parameter logic [PHASE_WIDTH-1:0] PRESET_A    = 64'h04CF41F212D77318,
   parameter logic [PHASE_WIDTH-1:0] PRESET_B    = 64'h01AA60F8B8911654,
   parameter logic [PHASE_WIDTH-1:0] PRESET_F    = 64'h1DC38C076704516D,
   parameter logic [PHASE_WIDTH-1:0] PRESET_G    = 64'h1D60D923295482C6,
   parameter int                     MAX_DIGITS  = 5
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   rx_valid,
   input  logic [7:0]             rx_byte,
   output logic [PHASE_WIDTH-1:0] phase_inc,
   output logic [GAIN_WIDTH-1:0]  cic_gain,
   output logic                   busy,
   output logic                   update_strobe,
   output logic                   cmd_error
);

   localparam int               ACC_W    = 17;
   localparam int               CNT_W    = $clog2(MAX_DIGITS + 1);
   localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_DIGITS);
   localparam logic [4:0]       LAST_BIT = 5'(ACC_W - 1);
   localparam logic [ACC_W-1:0] TEN      = ACC_W'(10);

   typedef enum logic [1:0] {IDLE, DIGITS, MULT} state_t;

   state_t                 state_q, state_d;
   logic [ACC_W-1:0]       acc_q, acc_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [PHASE_WIDTH-1:0] phase_q, phase_d;
   logic [GAIN_WIDTH-1:0]  gain_q, gain_d;
   logic                   busy_q, busy_d;
   logic                   upd_q, upd_d;
   logic                   err_q, err_d;
   logic [PHASE_WIDTH-1:0] prod_q, prod_d;
   logic [PHASE_WIDTH-1:0] mcand_q, mcand_d;
   logic [ACC_W-1:0]       mplier_q, mplier_d;
   logic [4:0]             bit_q, bit_d;

   logic                   is_digit;
   logic [PHASE_WIDTH-1:0] mult_sum;

   assign is_digit = (rx_byte >= 8'h30) && (rx_byte <= 8'h39);
   // Multiplicand shifts left each cycle, so bits beyond PHASE_WIDTH fall off: product is mod 2^PHASE_WIDTH.
   assign mult_sum = prod_q + (mplier_q[0] ? mcand_q : '0);

   always_comb begin
      state_d  = state_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      phase_d  = phase_q;
      gain_d   = gain_q;
      busy_d   = busy_q;
      upd_d    = 1'b0;
      err_d    = 1'b0;
      prod_d   = prod_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      bit_d    = bit_q;
      case (state_q)
         IDLE: begin
            if (rx_valid) begin
               case (rx_byte)
                  8'h30, 8'h31, 8'h32, 8'h33: gain_d = GAIN_WIDTH'(rx_byte[1:0]);
                  8'h61: begin phase_d = PRESET_A;             upd_d = 1'b1; end
                  8'h62: begin phase_d = PRESET_B;             upd_d = 1'b1; end
                  8'h66: begin phase_d = PRESET_F;             upd_d = 1'b1; end
                  8'h67: begin phase_d = PRESET_G;             upd_d = 1'b1; end
                  8'h6E: begin phase_d = phase_q - STEP_9KHZ;  upd_d = 1'b1; end
                  8'h6D: begin phase_d = phase_q + STEP_9KHZ;  upd_d = 1'b1; end
                  8'h6F: begin phase_d = phase_q - STEP_100HZ; upd_d = 1'b1; end
                  8'h70: begin phase_d = phase_q + STEP_100HZ; upd_d = 1'b1; end
                  8'h71: begin phase_d = phase_q - STEP_1KHZ;  upd_d = 1'b1; end
                  8'h72: begin phase_d = phase_q + STEP_1KHZ;  upd_d = 1'b1; end
                  8'h46: begin
                     acc_d   = '0;
                     cnt_d   = '0;
                     state_d = DIGITS;
                  end
                  default: ;
               endcase
            end
         end
         DIGITS: begin
            if (rx_valid) begin
               if (is_digit) begin
                  if (cnt_q < MAX_CNT) begin
                     acc_d = acc_q * TEN + ACC_W'(rx_byte[3:0]);
                     cnt_d = cnt_q + 1'b1;
                  end else begin
                     err_d   = 1'b1;
                     state_d = IDLE;
                  end
               end else if (rx_byte == 8'h0D) begin
                  if (cnt_q != '0) begin
                     state_d  = MULT;
                     busy_d   = 1'b1;
                     prod_d   = '0;
                     mcand_d  = STEP_1KHZ;
                     mplier_d = acc_q;
                     bit_d    = '0;
                  end else begin
                     err_d   = 1'b1;
                     state_d = IDLE;
                  end
               end else if (rx_byte == 8'h1B) begin
                  state_d = IDLE;
               end else begin
                  err_d   = 1'b1;
                  state_d = IDLE;
               end
            end
         end
         MULT: begin
            err_d    = rx_valid;
            prod_d   = mult_sum;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            bit_d    = bit_q + 5'd1;
            if (bit_q == LAST_BIT) begin
               phase_d = mult_sum;
               upd_d   = 1'b1;
               busy_d  = 1'b0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         acc_q    <= '0;
         cnt_q    <= '0;
         phase_q  <= PRESET_A;
         gain_q   <= '0;
         busy_q   <= 1'b0;
         upd_q    <= 1'b0;
         err_q    <= 1'b0;
         prod_q   <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         bit_q    <= '0;
      end else begin
         state_q  <= state_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         phase_q  <= phase_d;
         gain_q   <= gain_d;
         busy_q   <= busy_d;
         upd_q    <= upd_d;
         err_q    <= err_d;
         prod_q   <= prod_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         bit_q    <= bit_d;
      end
   end

   assign phase_inc     = phase_q;
   assign cic_gain      = gain_q;
   assign busy          = busy_q;
   assign update_strobe = upd_q;
   assign cmd_error     = err_q;

endmodule
